axi_tensor_rd: RTL and testbench

AXI4 read master that loads one 8×8 tile of 128-bit PE operand entries from DRAM into a registered tile buffer. It is the read-side counterpart of the tensor write-back path and sits between the DRAM AXI read channels and the PE array operand load.
- Issues a single INCR burst per request.
- Unpacks 256-bit beats into the tile, in the same layout the write-back path emits.
- Signals completion with a one-cycle pulse.

---
 rtl/axi_tensor_rd_if.sv | 26 ++
 rtl/axi_tensor_rd.sv | 170 +++++++++++++++++
 tb/tb_axi_tensor_rd.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_tensor_rd_if.sv
// AXI4 read-address and read-data channels between the tensor tile loader and DRAM.
interface axi_tensor_rd_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  axi_arvalid;
    logic                  axi_arready;
    logic [ADDR_WIDTH-1:0] axi_araddr;
    logic [7:0]            axi_arlen;
    logic [2:0]            axi_arsize;
    logic [1:0]            axi_arburst;
    logic                  axi_rvalid;
    logic                  axi_rready;
    logic [255:0]          axi_rdata;
    logic [1:0]            axi_rresp;
    logic                  axi_rlast;

    modport master (
        output axi_arvalid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_rready,
        input  axi_arready, axi_rvalid, axi_rdata, axi_rresp, axi_rlast
    );

    modport slave (
        input  axi_arvalid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_rready,
        output axi_arready, axi_rvalid, axi_rdata, axi_rresp, axi_rlast
    );
endinterface

// File: rtl/axi_tensor_rd.sv
// AXI4 read master loading one 8x8 tile of 128-bit PE operands in a single INCR burst.
// Optional AXI_RD_RESP_CHECK_EN enables the sticky rd_err response/rlast checker.
package params;
    typedef enum logic [1:0] {
        INT8 = 2'd0,
        FP16 = 2'd1,
        BF16 = 2'd2,
        FP32 = 2'd3
    } datatype_t;

    typedef struct packed {
        datatype_t datatype;
    } addrgen_t;
endpackage

module axi_tensor_rd #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   mixed,
    input  params::addrgen_t       addr_type,
    input  logic                   rd_enb,
    input  logic [ADDR_WIDTH-1:0]  base_addr,
    axi_tensor_rd_if.master        axi,
    output logic [7:0][7:0][127:0] tile,
    output logic                   rd_busy,
    output logic                   rd_done,
    output logic                   rd_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_ADDR = 2'd1,
        RD_DATA = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic                     mode_q;
    logic [4:0]               beat_cnt_q;
    logic [ADDR_WIDTH-1:0]    araddr_q;
    logic [7:0]               arlen_q;
    logic                     arvalid_q, rready_q, busy_q, done_q;
    logic                     arvalid_d, rready_d, busy_d, done_d;
    logic [7:0][7:0][127:0]   tile_q;

    logic                     start;
    logic                     ar_hs;
    logic                     r_hs;
    logic                     last_beat;
    logic                     mode_d;
    logic [ADDR_WIDTH-1:0]    addr_mask;

    assign start     = (state_q == IDLE) && rd_enb;
    assign ar_hs     = arvalid_q && axi.axi_arready;
    assign r_hs      = rready_q && axi.axi_rvalid;
    assign last_beat = (beat_cnt_q == (mode_q ? 5'd15 : 5'd31));
    // Special mode packs four FP16 half-entries per beat, so the burst is half as long.
    assign mode_d    = ~mixed && (addr_type.datatype == params::FP16);
    assign addr_mask = ~ADDR_WIDTH'(5'h1f);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (rd_enb) state_d = RD_ADDR;
            end
            RD_ADDR: begin
                if (ar_hs) state_d = RD_DATA;
            end
            RD_DATA: begin
                if (r_hs && last_beat) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        arvalid_d = (state_d == RD_ADDR);
        rready_d  = (state_d == RD_DATA);
        busy_d    = (state_d != IDLE);
        done_d    = (state_q == RD_DATA) && (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mode_q     <= 1'b0;
            beat_cnt_q <= 5'd0;
            araddr_q   <= '0;
            arlen_q    <= 8'd0;
        end else begin
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            if (start) begin
                mode_q     <= mode_d;
                beat_cnt_q <= 5'd0;
                araddr_q   <= base_addr & addr_mask;
                arlen_q    <= mode_d ? 8'd15 : 8'd31;
            end else if (r_hs) begin
                beat_cnt_q <= beat_cnt_q + 5'd1;
            end
        end
    end

    // Entry e lives at tile[e[5:3]][e[2:0]]; each beat fills two (normal) or four (special) entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tile_q <= '0;
        end else if (r_hs) begin
            if (mode_q) begin
                for (int k = 0; k < 4; k++) begin
                    tile_q[beat_cnt_q[3:1]][{beat_cnt_q[0], 2'(k)}] <=
                        {64'd0, axi.axi_rdata[64*k +: 64]};
                end
            end else begin
                tile_q[beat_cnt_q[4:2]][{beat_cnt_q[1:0], 1'b0}] <= axi.axi_rdata[127:0];
                tile_q[beat_cnt_q[4:2]][{beat_cnt_q[1:0], 1'b1}] <= axi.axi_rdata[255:128];
            end
        end
    end

`ifdef AXI_RD_RESP_CHECK_EN
    logic err_q;
    logic beat_err;

    // rlast must coincide exactly with the final counted beat; the count itself never follows rlast.
    assign beat_err = (axi.axi_rresp != 2'b00) || (axi.axi_rlast != last_beat);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (start) begin
            err_q <= 1'b0;
        end else if (r_hs && beat_err) begin
            err_q <= 1'b1;
        end
    end

    assign rd_err = err_q;
`else
    assign rd_err = 1'b0;
`endif

    assign axi.axi_arvalid = arvalid_q;
    assign axi.axi_araddr  = araddr_q;
    assign axi.axi_arlen   = arlen_q;
    assign axi.axi_arsize  = 3'b101;
    assign axi.axi_arburst = 2'b01;
    assign axi.axi_rready  = rready_q;

    assign tile    = tile_q;
    assign rd_busy = busy_q;
    assign rd_done = done_q;

endmodule

// File: tb/tb_axi_tensor_rd.sv
// Scoreboard bench for axi_tensor_rd: stimulus pushes expected AR/completion records, a monitor checks them.
`timescale 1ns/1ps
module tb_axi_tensor_rd;
    localparam int ADDR_WIDTH = 32;
`ifdef AXI_RD_RESP_CHECK_EN
    localparam bit EXP_ERR = 1'b1;
`else
    localparam bit EXP_ERR = 1'b0;
`endif

    typedef logic [7:0][7:0][127:0] tile_t;
    typedef struct { logic [31:0] addr; logic [7:0] len; } ar_exp_t;
    typedef struct { tile_t tile; bit err; int beats; int lat; } done_exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             mixed = 1'b0;
    logic             rd_enb = 1'b0;
    logic [31:0]      base_addr = '0;
    params::addrgen_t addr_type;
    tile_t            tile;
    logic             rd_busy, rd_done, rd_err;

    axi_tensor_rd_if #(.ADDR_WIDTH(ADDR_WIDTH)) axi ();

    axi_tensor_rd #(.ADDR_WIDTH(ADDR_WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mixed     (mixed),
        .addr_type (addr_type),
        .rd_enb    (rd_enb),
        .base_addr (base_addr),
        .axi       (axi),
        .tile      (tile),
        .rd_busy   (rd_busy),
        .rd_done   (rd_done),
        .rd_err    (rd_err)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int cyc = 0, enb_cyc = 0, last_hs_cyc = 0, beats_seen = 0;
    ar_exp_t   ar_q[$];
    done_exp_t done_q[$];
    bit        done_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
        end
    endtask

    task automatic chk_tile(input string name, input tile_t got, input tile_t exp);
        int bad;
        bad = -1;
        checks++;
        for (int e = 0; e < 64; e++)
            if (bad < 0 && got[e/8][e%8] !== exp[e/8][e%8]) bad = e;
        if (bad >= 0) begin
            failures++;
            $display("FAIL %s entry=%0d got=0x%0h exp=0x%0h", name, bad,
                     got[bad/8][bad%8], exp[bad/8][bad%8]);
        end
    endtask

    function automatic tile_t tile_normal();
        tile_t t;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) t[r][c] = 128'(8*r + c);
        return t;
    endfunction

    function automatic tile_t tile_special();
        tile_t t;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) t[r][c] = {64'd0, 64'(8*r + c)};
        return t;
    endfunction

    // Monitor: AR handshakes and completions are popped against the scoreboard.
    always @(negedge clk) begin
        ar_exp_t   ea;
        done_exp_t ed;
        if (rst_n) begin
            if (axi.axi_arvalid && axi.axi_arready) begin
                if (ar_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_ar got_addr=0x%0h exp=none", axi.axi_araddr);
                end else begin
                    ea = ar_q.pop_front();
                    chk("araddr", 64'(axi.axi_araddr), 64'(ea.addr));
                    chk("arlen", 64'(axi.axi_arlen), 64'(ea.len));
                    chk("arsize", 64'(axi.axi_arsize), 64'd5);
                    chk("arburst", 64'(axi.axi_arburst), 64'd1);
                end
            end
            if (done_prev) chk("rd_done_one_cycle", 64'(rd_done), 64'd0);
            if (rd_done) begin
                if (done_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_done got=1 exp=0");
                end else begin
                    ed = done_q.pop_front();
                    chk_tile("tile_at_done", tile, ed.tile);
                    chk("rd_err_at_done", 64'(rd_err), 64'(ed.err));
                    chk("beats_accepted", 64'(beats_seen), 64'(ed.beats));
                    chk("busy_at_done", 64'(rd_busy), 64'd0);
                    // rd_done is high in the cycle opened by the final R handshake edge.
                    chk("done_after_last_beat", 64'(cyc - last_hs_cyc), 64'd0);
                    if (ed.lat >= 0) chk("latency", 64'(cyc - enb_cyc), 64'(ed.lat));
                end
            end
            done_prev = rd_done;
        end else begin
            done_prev = 1'b0;
        end
    end

    task automatic issue(input bit mx, input params::datatype_t dt, input logic [31:0] base,
                         input logic [31:0] exp_addr, input logic [7:0] exp_len, input int nbeats,
                         input tile_t exp_tile, input bit exp_err, input int lat);
        ar_exp_t   ea;
        done_exp_t ed;
        ea.addr = exp_addr; ea.len = exp_len;
        ed.tile = exp_tile; ed.err = exp_err; ed.beats = nbeats; ed.lat = lat;
        ar_q.push_back(ea);
        done_q.push_back(ed);
        beats_seen = 0;
        mixed = mx;
        addr_type.datatype = dt;
        base_addr = base;
        rd_enb = 1'b1;
        enb_cyc = cyc;
        @(posedge clk); #1;
        rd_enb = 1'b0;
    endtask

    // Slave model for one burst, with optional mid-burst rd_enb pulse or reset.
    task automatic serve(input int nbeats, input bit special, input int ar_delay, input bit toggle,
                         input int err_beat, input int enb_at, input int rst_at, output bit was_reset);
        int held, guard, b;
        bit seen_valid, dropped, hs, phase;
        held = 0; guard = 0; b = 0; seen_valid = 0; dropped = 0; phase = 1'b1;
        was_reset = 1'b0;
        while (!(axi.axi_arvalid && axi.axi_arready) && guard < 100) begin
            if (axi.axi_arvalid) begin
                seen_valid = 1'b1;
                if (held >= ar_delay) axi.axi_arready = 1'b1;
                else held++;
            end else if (seen_valid) begin
                dropped = 1'b1;
            end
            if (!(axi.axi_arvalid && axi.axi_arready)) begin
                @(posedge clk); #1; guard++;
            end
        end
        if (guard >= 100) begin
            checks++; failures++;
            $display("FAIL ar_timeout got=no_handshake exp=handshake");
            return;
        end
        if (ar_delay > 0) chk("arvalid_held", 64'(dropped), 64'd0);
        @(posedge clk); #1;
        if (ar_delay > 0) axi.axi_arready = 1'b0;
        guard = 0;
        while (b < nbeats && guard < 1000) begin
            if (toggle) phase = ~phase;
            axi.axi_rvalid = phase;
            axi.axi_rdata  = special ? {64'(4*b+3), 64'(4*b+2), 64'(4*b+1), 64'(4*b)}
                                     : {128'(2*b+1), 128'(2*b)};
            axi.axi_rresp  = (b == err_beat) ? 2'b10 : 2'b00;
            axi.axi_rlast  = (b == nbeats - 1);
            hs = phase && axi.axi_rready;
            @(posedge clk); #1; guard++;
            rd_enb = 1'b0;
            if (hs) begin
                b++;
                beats_seen++;
                last_hs_cyc = cyc;
                if (b - 1 == err_beat) chk("rd_err_after_bad_beat", 64'(rd_err), 64'(EXP_ERR));
                if (b == enb_at) rd_enb = 1'b1;
                if (b == rst_at) begin
                    #2;
                    rst_n = 1'b0;
                    axi.axi_rvalid = 1'b0;
                    done_q.delete();
                    was_reset = 1'b1;
                    return;
                end
            end
        end
        axi.axi_rvalid = 1'b0;
        axi.axi_rlast  = 1'b0;
        if (b < nbeats) begin
            checks++; failures++;
            $display("FAIL r_timeout got_beats=%0d exp=%0d", b, nbeats);
        end
    endtask

    task automatic wait_done();
        int g;
        g = 0;
        while (done_q.size() > 0 && g < 50) begin
            @(posedge clk); g++;
        end
        if (done_q.size() > 0) begin
            checks++; failures++;
            $display("FAIL done_timeout got=pending exp=rd_done");
            done_q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state();
        chk("rst_arvalid", 64'(axi.axi_arvalid), 64'd0);
        chk("rst_rready", 64'(axi.axi_rready), 64'd0);
        chk("rst_araddr", 64'(axi.axi_araddr), 64'd0);
        chk("rst_busy", 64'(rd_busy), 64'd0);
        chk("rst_done", 64'(rd_done), 64'd0);
        chk("rst_err", 64'(rd_err), 64'd0);
        chk_tile("rst_tile", tile, '0);
    endtask

    initial begin
        bit rs;
        addr_type.datatype = params::INT8;
        axi.axi_arready = 1'b0;
        axi.axi_rvalid  = 1'b0;
        axi.axi_rdata   = '0;
        axi.axi_rresp   = 2'b00;
        axi.axi_rlast   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state();
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Normal burst, slave always ready: rd_done 34 edges after the rd_enb cycle.
        axi.axi_arready = 1'b1;
        issue(1'b1, params::INT8, 32'h1000, 32'h1000, 8'd31, 32, tile_normal(), 1'b0, 34);
        serve(32, 1'b0, 0, 1'b0, -1, -1, -1, rs);
        wait_done();

        // Special FP16 mode with unaligned base address.
        issue(1'b0, params::FP16, 32'h2013, 32'h2000, 8'd15, 16, tile_special(), 1'b0, 18);
        serve(16, 1'b1, 0, 1'b0, -1, -1, -1, rs);
        wait_done();

        // Backpressure: arready late by 5 cycles, rvalid every other cycle.
        axi.axi_arready = 1'b0;
        issue(1'b1, params::FP16, 32'h1000, 32'h1000, 8'd31, 32, tile_normal(), 1'b0, -1);
        serve(32, 1'b0, 5, 1'b1, -1, -1, -1, rs);
        wait_done();

        // rd_enb pulsed at beat 10 must not start a second burst.
        axi.axi_arready = 1'b1;
        issue(1'b0, params::BF16, 32'h1040, 32'h1040, 8'd31, 32, tile_normal(), 1'b0, -1);
        serve(32, 1'b0, 0, 1'b0, -1, 10, -1, rs);
        wait_done();
        repeat (4) @(posedge clk);
        #1;
        chk("idle_after_ignored_enb", 64'(rd_busy), 64'd0);

        // Asynchronous reset at beat 12, then a clean burst.
        issue(1'b1, params::INT8, 32'h3000, 32'h3000, 8'd31, 32, tile_normal(), 1'b0, -1);
        serve(32, 1'b0, 0, 1'b0, -1, -1, 12, rs);
        chk("reset_reached", 64'(rs), 64'd1);
        #1;
        check_reset_state();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue(1'b0, params::INT8, 32'h4000, 32'h4000, 8'd31, 32, tile_normal(), 1'b0, 34);
        serve(32, 1'b0, 0, 1'b0, -1, -1, -1, rs);
        wait_done();

        // Error response on beat 4; the next accepted rd_enb clears rd_err.
        issue(1'b1, params::INT8, 32'h5000, 32'h5000, 8'd31, 32, tile_normal(), EXP_ERR, 34);
        serve(32, 1'b0, 0, 1'b0, 4, -1, -1, rs);
        wait_done();
        issue(1'b1, params::INT8, 32'h6000, 32'h6000, 8'd31, 32, tile_normal(), 1'b0, 34);
        chk("rd_err_cleared", 64'(rd_err), 64'd0);
        serve(32, 1'b0, 0, 1'b0, -1, -1, -1, rs);
        wait_done();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
